// File: rtl/axis_pkg.sv
// Shared AXI constants and helpers for the stream write arbiter.
package axis_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_NORMAL_ACCESS = 2'b00;
  localparam logic [3:0] AXI_CACHE_ZERO    = 4'b0000;
  localparam logic [2:0] AXI_PROT_ZERO     = 3'b000;
  localparam logic [3:0] AXI_QOS_ZERO      = 4'b0000;

  // AWSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] burst_size(input int data_width);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_width / 8)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axis_order_fifo.sv
// Grant-order FIFO: holds the channel index of every accepted burst until its last W beat.
module axis_order_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AWIDTH:0]   count_o
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (AWIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AWIDTH+1)'(1);
        2'b01:   count_q <= count_q - (AWIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_write_arb.sv
// N-channel AXI write arbiter: round-robin AW, W ordered by grant FIFO, B routed by BID.
// Optional BRESP error counting is enabled with the AXIS_BRESP_CHECK_EN macro.
module axis_write_arb
  import axis_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int ORDER_AWIDTH   = 3,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS-1:0]                ch_awvalid,
  input  logic [CHANNELS*AXI_ADDR_WIDTH-1:0] ch_awaddr,
  input  logic [CHANNELS*AXI_LEN_WIDTH-1:0]  ch_awlen,
  output logic [CHANNELS-1:0]                ch_awready,
  input  logic [CHANNELS-1:0]                ch_wvalid,
  input  logic [CHANNELS*AXI_DATA_WIDTH-1:0] ch_wdata,
  input  logic [CHANNELS-1:0]                ch_wlast,
  output logic [CHANNELS-1:0]                ch_wready,
  output logic [CHANNELS-1:0]                ch_bdone,
  output logic                               axi_awvalid,
  input  logic                               axi_awready,
  output logic [AXI_ID_WIDTH-1:0]            axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]           axi_awlen,
  output logic [2:0]                         axi_awsize,
  output logic [1:0]                         axi_awburst,
  output logic [1:0]                         axi_awlock,
  output logic [3:0]                         axi_awcache,
  output logic [2:0]                         axi_awprot,
  output logic [3:0]                         axi_awqos,
  output logic                               axi_wvalid,
  input  logic                               axi_wready,
  output logic [AXI_ID_WIDTH-1:0]            axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]          axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]        axi_wstrb,
  output logic                               axi_wlast,
  input  logic                               axi_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]            axi_bid,
  input  logic [1:0]                         axi_bresp,
  output logic                               axi_bready,
  output logic [15:0]                        err_count,
  output logic                               err_sticky
);

  localparam int CH_W = $clog2(CHANNELS);

  logic                      awvalid_q;
  logic [AXI_ID_WIDTH-1:0]   awid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_LEN_WIDTH-1:0]  awlen_q;
  logic [CH_W-1:0]           rr_q;
  logic [CHANNELS-1:0]       bdone_q, bdone_d;

  logic            grant_found, grant_valid;
  logic [CH_W-1:0] grant_idx, head_idx;
  logic            fifo_full, fifo_empty, w_pop;
  logic [ORDER_AWIDTH:0] fifo_count_unused;

  assign axi_awsize  = burst_size(AXI_DATA_WIDTH);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awlock  = AXI_NORMAL_ACCESS;
  assign axi_awcache = AXI_CACHE_ZERO;
  assign axi_awprot  = AXI_PROT_ZERO;
  assign axi_awqos   = AXI_QOS_ZERO;
  assign axi_wstrb   = '1;
  assign axi_bready  = 1'b1;
  assign axi_awvalid = awvalid_q;
  assign axi_awid    = awid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign ch_bdone    = bdone_q;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!grant_found && ch_awvalid[(int'(rr_q) + k) % CHANNELS]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((int'(rr_q) + k) % CHANNELS);
      end
    end
  end

  assign grant_valid = grant_found && (!awvalid_q || axi_awready) && !fifo_full;

  always_comb begin
    ch_awready = '0;
    if (grant_valid) ch_awready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      rr_q      <= CH_W'(CHANNELS - 1);
    end else if (grant_valid) begin
      awvalid_q <= 1'b1;
      awid_q    <= AXI_ID_WIDTH'(grant_idx);
      awaddr_q  <= ch_awaddr[int'(grant_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      awlen_q   <= ch_awlen[int'(grant_idx)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
      rr_q      <= grant_idx;
    end else if (axi_awready) begin
      awvalid_q <= 1'b0;
    end
  end

  axis_order_fifo #(
    .WIDTH  (CH_W),
    .AWIDTH (ORDER_AWIDTH)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant_valid),
    .data_i  (grant_idx),
    .pop_i   (w_pop),
    .head_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  // W beats may run ahead of their AW; the FIFO head alone decides who owns the bus.
  always_comb begin
    axi_wvalid = 1'b0;
    axi_wdata  = '0;
    axi_wlast  = 1'b0;
    axi_wid    = '0;
    ch_wready  = '0;
    if (!fifo_empty) begin
      axi_wvalid          = ch_wvalid[head_idx];
      axi_wdata           = ch_wdata[int'(head_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      axi_wlast           = ch_wlast[head_idx];
      axi_wid             = AXI_ID_WIDTH'(head_idx);
      ch_wready[head_idx] = axi_wready;
    end
  end

  assign w_pop = axi_wvalid && axi_wready && axi_wlast;

  always_comb begin
    bdone_d = '0;
    if (axi_bvalid && (int'(axi_bid) < CHANNELS)) bdone_d[axi_bid[CH_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bdone_q <= '0;
    else     bdone_q <= bdone_d;
  end

`ifdef AXIS_BRESP_CHECK_EN
  logic [15:0] err_count_q;
  logic        err_sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else if (axi_bvalid && (axi_bresp != AXI_RESP_OKAY)) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      err_sticky_q <= 1'b1;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^axi_bresp;
  assign err_count    = '0;
  assign err_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_write_arb.sv
// Directed bench for axis_write_arb: AW/W scoreboard monitor plus targeted arbitration, FIFO-full, B and reset cases.
module tb_axis_write_arb;

  localparam int CH    = 4;
  localparam int OAW   = 2;
  localparam int IDW   = 8;
  localparam int LENW  = 8;
  localparam int ADDRW = 32;
  localparam int DATAW = 64;

  typedef struct {
    int tag;
    int len;
  } burst_t;

  logic                  clk, rst;
  logic [CH-1:0]         awv, wv, wl;
  logic [CH*ADDRW-1:0]   awaddr;
  logic [CH*LENW-1:0]    awlen;
  logic [CH*DATAW-1:0]   wdata;
  logic [CH-1:0]         ch_awready, ch_wready, ch_bdone;
  logic                  axi_awvalid, axi_awready;
  logic [IDW-1:0]        axi_awid, axi_wid, axi_bid;
  logic [ADDRW-1:0]      axi_awaddr;
  logic [LENW-1:0]       axi_awlen;
  logic [2:0]            axi_awsize, axi_awprot;
  logic [1:0]            axi_awburst, axi_awlock, axi_bresp;
  logic [3:0]            axi_awcache, axi_awqos;
  logic                  axi_wvalid, axi_wready, axi_wlast;
  logic [DATAW-1:0]      axi_wdata;
  logic [DATAW/8-1:0]    axi_wstrb;
  logic                  axi_bvalid, axi_bready;
  logic [15:0]           err_count;
  logic                  err_sticky;

  int checks = 0;
  int failures = 0;

  logic [IDW+ADDRW+LENW-1:0] aw_exp_q[$];
  logic [IDW+DATAW:0]        w_exp_q[$];
  logic [IDW+ADDRW+LENW-1:0] aw_e;
  logic [IDW+DATAW:0]        w_e;
  burst_t                    chq[CH][$];
  int                        beat[CH];

  axis_write_arb #(
    .CHANNELS(CH), .ORDER_AWIDTH(OAW), .AXI_ID_WIDTH(IDW), .AXI_LEN_WIDTH(LENW),
    .AXI_ADDR_WIDTH(ADDRW), .AXI_DATA_WIDTH(DATAW)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_awvalid(awv), .ch_awaddr(awaddr), .ch_awlen(awlen), .ch_awready(ch_awready),
    .ch_wvalid(wv), .ch_wdata(wdata), .ch_wlast(wl), .ch_wready(ch_wready), .ch_bdone(ch_bdone),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wid(axi_wid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .err_count(err_count), .err_sticky(err_sticky)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDRW-1:0] a_of(input int ch, input int tag);
    return ADDRW'(32'h1000_0000 + ch * 32'h1000 + tag * 32'h40);
  endfunction

  function automatic logic [DATAW-1:0] mk_data(input int ch, input int tag, input int b);
    return {16'(ch), 16'(tag), 16'hC0DE, 16'(b)};
  endfunction

  // Driver tasks
  task automatic req(input int ch, input int tag, input int len);
    burst_t bt;
    awv[ch] = 1'b1;
    awaddr[ch*ADDRW +: ADDRW] = a_of(ch, tag);
    awlen[ch*LENW +: LENW] = LENW'(len);
    bt.tag = tag;
    bt.len = len;
    chq[ch].push_back(bt);
  endtask

  task automatic expect_burst(input int ch, input int tag, input int len);
    aw_exp_q.push_back({IDW'(ch), a_of(ch, tag), LENW'(len)});
    for (int b = 0; b <= len; b++)
      w_exp_q.push_back({IDW'(ch), mk_data(ch, tag, b), (b == len)});
  endtask

  task automatic run_aw(input int budget, output int cycles);
    logic [CH-1:0] g;
    cycles = 0;
    while (awv != '0 && cycles < budget) begin
      @(negedge clk);
      g = awv & ch_awready;
      @(posedge clk); #1;
      awv = awv & ~g;
      cycles++;
    end
    chk("aw_requests_granted", 64'(awv), 64'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((aw_exp_q.size() != 0 || w_exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_aw_left", 64'(aw_exp_q.size()), 64'd0);
    chk("drain_w_left", 64'(w_exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Per-channel W engines: present the current burst's beat, advance on handshake.
  initial begin
    logic [CH-1:0] hs;
    wv = '0; wl = '0; wdata = '0;
    for (int i = 0; i < CH; i++) beat[i] = 0;
    forever begin
      @(negedge clk);
      hs = wv & ch_wready;
      @(posedge clk); #1;
      for (int i = 0; i < CH; i++) begin
        if (hs[i] && chq[i].size() > 0) begin
          if (beat[i] == chq[i][0].len) begin
            void'(chq[i].pop_front());
            beat[i] = 0;
          end else begin
            beat[i]++;
          end
        end
        if (chq[i].size() > 0) begin
          wv[i] = 1'b1;
          wl[i] = (beat[i] == chq[i][0].len);
          wdata[i*DATAW +: DATAW] = mk_data(i, chq[i][0].tag, beat[i]);
        end else begin
          wv[i] = 1'b0;
          wl[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_awvalid && axi_awready) begin
        if (aw_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL aw_unexpected actual_awid=%0d expected=none", axi_awid);
        end else begin
          aw_e = aw_exp_q.pop_front();
          chk("awid", 64'(axi_awid), 64'(aw_e[IDW+ADDRW+LENW-1 -: IDW]));
          chk("awaddr", 64'(axi_awaddr), 64'(aw_e[ADDRW+LENW-1 -: ADDRW]));
          chk("awlen", 64'(axi_awlen), 64'(aw_e[LENW-1:0]));
        end
      end
      if (axi_wvalid && axi_wready) begin
        if (w_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL w_unexpected actual_wid=%0d expected=none", axi_wid);
        end else begin
          w_e = w_exp_q.pop_front();
          chk("wid", 64'(axi_wid), 64'(w_e[IDW+DATAW -: IDW]));
          chk("wdata", axi_wdata, w_e[DATAW:1]);
          chk("wlast", 64'(axi_wlast), 64'(w_e[0]));
          chk("wready_onehot", 64'($countones(ch_wready)), 64'd1);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1;
    awv = '0; awaddr = '0; awlen = '0;
    axi_awready = 1'b0; axi_wready = 1'b0;
    axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = 2'b00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_awaddr", 64'(axi_awaddr), 64'd0);
    chk("rst_awlen", 64'(axi_awlen), 64'd0);
    chk("rst_awid", 64'(axi_awid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_bdone", 64'(ch_bdone), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk("awsize", 64'(axi_awsize), 64'd3);
    chk("awburst", 64'(axi_awburst), 64'd1);
    chk("awcache", 64'({axi_awlock, axi_awcache, axi_awprot, axi_awqos}), 64'd0);
    chk("wstrb", 64'(axi_wstrb), 64'hFF);
    chk("bready", 64'(axi_bready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    axi_awready = 1'b1; axi_wready = 1'b1;
    @(posedge clk); #1;

    // All four request together: grants 0,1,2,3 on consecutive cycles.
    for (int c = 0; c < 4; c++) req(c, c + 1, 1);
    for (int c = 0; c < 4; c++) expect_burst(c, c + 1, 1);
    run_aw(20, cyc);
    chk("rr_grant_cycles", 64'(cyc), 64'd4);
    wait_drain(200);

    // Ch2 len 3 then ch1 len 0: W carries 4 beats of ch2 then 1 of ch1.
    req(2, 10, 3);
    expect_burst(2, 10, 3);
    run_aw(20, cyc);
    req(1, 11, 0);
    expect_burst(1, 11, 0);
    run_aw(20, cyc);
    wait_drain(200);

    // AW stall: ch3 (after rr=1) wins and is held stable for 10 cycles.
    axi_awready = 1'b0;
    req(0, 20, 0);
    req(3, 21, 2);
    expect_burst(3, 21, 2);
    expect_burst(0, 20, 0);
    @(negedge clk);
    chk("stall_first_grant", 64'(ch_awready), 64'b1000);
    @(posedge clk); #1;
    awv[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_awvalid", 64'(axi_awvalid), 64'd1);
      chk("stall_awid", 64'(axi_awid), 64'd3);
      chk("stall_awaddr", 64'(axi_awaddr), 64'(a_of(3, 21)));
      chk("stall_awlen", 64'(axi_awlen), 64'd2);
      chk("stall_awready", 64'(ch_awready), 64'd0);
    end
    @(posedge clk); #1;
    axi_awready = 1'b1;
    run_aw(20, cyc);
    chk("stall_b2b_cycles", 64'(cyc), 64'd1);
    wait_drain(200);

    // FIFO full: 4 grants (rr=0 -> 1,2,3,0), then ch_awready stays low until a wlast pop.
    axi_wready = 1'b0;
    for (int c = 0; c < 4; c++) req(c, 30 + c, 0);
    expect_burst(1, 31, 0);
    expect_burst(2, 32, 0);
    expect_burst(3, 33, 0);
    expect_burst(0, 30, 0);
    run_aw(20, cyc);
    chk("full_fill_cycles", 64'(cyc), 64'd4);
    req(0, 40, 0);
    req(1, 41, 0);
    expect_burst(1, 41, 0);
    expect_burst(0, 40, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_block", 64'(ch_awready), 64'd0);
    end
    chk("full_head_wvalid", 64'(axi_wvalid), 64'd1);
    @(posedge clk); #1;
    axi_wready = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_block", 64'(ch_awready), 64'd0);
    run_aw(20, cyc);
    chk("full_resume_cycles", 64'(cyc), 64'd2);
    wait_drain(200);

    // B routing and error accounting.
    axi_bvalid = 1'b1; axi_bid = 8'd1; axi_bresp = 2'b10;
    @(negedge clk);
    chk("bdone_latency", 64'(ch_bdone), 64'd0);
    @(posedge clk); #1;
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    @(negedge clk);
    chk("bdone_bid1", 64'(ch_bdone), 64'b0010);
`ifdef AXIS_BRESP_CHECK_EN
    chk("err_count_slverr", 64'(err_count), 64'd1);
    chk("err_sticky_slverr", 64'(err_sticky), 64'd1);
`else
    chk("err_count_off", 64'(err_count), 64'd0);
    chk("err_sticky_off", 64'(err_sticky), 64'd0);
`endif
    @(negedge clk);
    chk("bdone_pulse_end", 64'(ch_bdone), 64'd0);
    @(posedge clk); #1;
    axi_bvalid = 1'b1; axi_bid = 8'd5;
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    @(negedge clk);
    chk("bdone_bid_oob", 64'(ch_bdone), 64'd0);
    @(posedge clk); #1;
    axi_bvalid = 1'b1; axi_bid = 8'd3;
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    @(negedge clk);
    chk("bdone_bid3", 64'(ch_bdone), 64'b1000);
`ifdef AXIS_BRESP_CHECK_EN
    chk("err_count_okay", 64'(err_count), 64'd1);
`else
    chk("err_count_okay", 64'(err_count), 64'd0);
`endif
    @(posedge clk); #1;

    // Reset mid-burst clears everything; ch0 wins first afterwards.
    axi_awready = 1'b0; axi_wready = 1'b0;
    req(2, 50, 3);
    @(negedge clk);
    @(posedge clk); #1;
    awv[2] = 1'b0;
    @(negedge clk);
    chk("pre_reset_awvalid", 64'(axi_awvalid), 64'd1);
    chk("pre_reset_wvalid", 64'(axi_wvalid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("reset_awvalid", 64'(axi_awvalid), 64'd0);
    chk("reset_wvalid", 64'(axi_wvalid), 64'd0);
    awv = '0;
    aw_exp_q.delete();
    w_exp_q.delete();
    for (int i = 0; i < CH; i++) begin
      chq[i].delete();
      beat[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    axi_awready = 1'b1; axi_wready = 1'b1;
    req(2, 60, 0);
    req(0, 61, 0);
    expect_burst(0, 61, 0);
    expect_burst(2, 60, 0);
    @(negedge clk);
    chk("post_reset_first_grant", 64'(ch_awready), 64'b0001);
    @(posedge clk); #1;
    awv[0] = 1'b0;
    run_aw(20, cyc);
    wait_drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
